// File: rtl/jt89_wrbuf_mem.sv
// Write-buffer storage: 2**AW x 8 simple dual-port RAM.
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata asynchronous read.
module jt89_wrbuf_mem #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] ram [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[waddr] <= wdata;
        end
    end

    // Combinational read keeps this in distributed RAM.
    assign rdata = ram[raddr];

endmodule

// File: rtl/jt89_wrbuf.sv
// FIFO write buffer replaying CPU/VGM bytes to the jt89 write port.
// Ports: clk, rst (sync, high); cpu_wr/cpu_din push side with full/empty/
// level/ovf/ovf_clr; psg_din/psg_wr_n/psg_ready to jt89; busy status.
module jt89_wrbuf #(
    parameter int AW   = 4,
    parameter int TOUT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_din,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level,
    output logic        ovf,
    input  logic        ovf_clr,
    output logic [7:0]  psg_din,
    output logic        psg_wr_n,
    input  logic        psg_ready,
    output logic        busy
);

    localparam int TW = $clog2(TOUT + 1);
    localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_STROBE  = 2'd1;
    localparam logic [1:0] S_WAIT_LO = 2'd2;
    localparam logic [1:0] S_WAIT_HI = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = S_IDLE,
        STROBE  = S_STROBE,
        WAIT_LO = S_WAIT_LO,
        WAIT_HI = S_WAIT_HI
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    din_q, din_d;
    logic          wr_n_q, wr_n_d;
    logic          busy_q, busy_d;

    logic       pop;
    logic       push_ok;
    logic       drop;
    logic [7:0] head;

    jt89_wrbuf_mem #(
        .AW(AW)
    ) u_mem (
        .clk  (clk),
        .we   (push_ok),
        .waddr(wr_ptr_q),
        .wdata(cpu_din),
        .raddr(rd_ptr_q),
        .rdata(head)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        din_d   = din_q;
        wr_n_d  = 1'b1;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Strobe is registered, so it is set up here.
                if (!empty_q && psg_ready) begin
                    pop     = 1'b1;
                    din_d   = head;
                    wr_n_d  = 1'b0;
                    state_d = STROBE;
                end
            end
            STROBE: begin
                tmr_d   = '0;
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                // Timeout covers a PSG that never drops ready.
                if (!psg_ready || tmr_q == TW'(TOUT - 1)) begin
                    state_d = WAIT_HI;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            WAIT_HI: begin
                if (psg_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // A pop in the same cycle frees a slot for a push into a full FIFO.
        push_ok  = cpu_wr && (!full_q || pop);
        drop     = cpu_wr && !push_ok;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
        full_d   = (count_d == DEPTH);
        empty_d  = (count_d == '0);
        // A drop wins over a simultaneous clear.
        ovf_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        busy_d   = (state_d != IDLE) || !empty_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            din_q    <= 8'h00;
            wr_n_q   <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            din_q    <= din_d;
            wr_n_q   <= wr_n_d;
            busy_q   <= busy_d;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = count_q;
    assign ovf      = ovf_q;
    assign psg_din  = din_q;
    assign psg_wr_n = wr_n_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_jt89_wrbuf.sv
// Self-checking bench for jt89_wrbuf with a simple PSG ready model.
// Ports: none; drives clk/rst/cpu side and models jt89 ready.
module tb_jt89_wrbuf;

    localparam int AW    = 2;
    localparam int TOUT  = 7;
    localparam int DEPTH = 4;
    localparam int BUSY  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        ovf_clr;
    logic        full;
    logic        empty;
    logic [AW:0] level;
    logic        ovf;
    logic [7:0]  psg_din;
    logic        psg_wr_n;
    logic        busy;

    // mode 0: ready held low, 1: ready tied high, 2: busy after each strobe
    int  mode = 0;
    int  busy_cnt = 0;
    wire psg_ready = (mode == 1) || (mode == 2 && busy_cnt == 0);

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         dbl_low = 0;
    logic       prev_low = 1'b0;
    logic [7:0] obs[$];
    int         obs_t[$];
    logic [7:0] exp_q[$];

    jt89_wrbuf #(
        .AW  (AW),
        .TOUT(TOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_wr   (cpu_wr),
        .cpu_din  (cpu_din),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .psg_din  (psg_din),
        .psg_wr_n (psg_wr_n),
        .psg_ready(psg_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // PSG side: log every low strobe cycle and start a busy window.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        if (psg_wr_n === 1'b0) begin
            obs.push_back(psg_din);
            obs_t.push_back(cyc);
            busy_cnt = BUSY;
            if (prev_low) dbl_low = dbl_low + 1;
        end
        prev_low = (psg_wr_n === 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        cpu_din = b;
        cpu_wr  = 1'b1;
        tick();
        cpu_wr  = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k = 0;
        while (obs.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (obs.size() < n) begin
            errors++;
            $display("FAIL wait_strobes: got %0d strobes, need %0d",
                     obs.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b need 0", busy);
        end
    endtask

    task automatic cmp_order(input string name);
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d bytes, need %0d",
                     name, obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h need %h",
                         name, i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic chk_reset_outs(input string name);
        checks++;
        if ({psg_wr_n, psg_din, ovf, full, empty, level, busy} !==
            {1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL %s: wr_n=%b din=%h ovf=%b full=%b empty=%b lvl=%0d busy=%b need 1 00 0 0 1 0 0",
                     name, psg_wr_n, psg_din, ovf, full, empty, level, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mode = 0;
        tick();
        tick();
        chk_reset_outs("reset");
        rst = 1'b0;
        tick();
        chk_reset_outs("reset_release");
    endtask

    task automatic test_latency();
        mode = 1;
        obs.delete();
        obs_t.delete();
        push(8'h9F);
        checks++;
        if (psg_wr_n !== 1'b1) begin
            errors++;
            $display("FAIL lat_c1: wr_n=%b need 1", psg_wr_n);
        end
        tick();
        checks++;
        if (psg_wr_n !== 1'b0 || psg_din !== 8'h9F) begin
            errors++;
            $display("FAIL lat_c2: wr_n=%b din=%h need 0 9f",
                     psg_wr_n, psg_din);
        end
        tick();
        checks++;
        if (psg_wr_n !== 1'b1 || empty !== 1'b1 || psg_din !== 8'h9F) begin
            errors++;
            $display("FAIL lat_c3: wr_n=%b empty=%b din=%h need 1 1 9f",
                     psg_wr_n, empty, psg_din);
        end
        wait_idle(40);
    endtask

    task automatic test_burst();
        mode = 2;
        obs.delete();
        obs_t.delete();
        exp_q = '{8'h80, 8'h0A, 8'h90};
        cpu_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_din = exp_q[i];
            tick();
        end
        cpu_wr = 1'b0;
        wait_obs(3, 200);
        cmp_order("burst");
        for (int i = 1; i < obs_t.size(); i++) begin
            checks++;
            if (obs_t[i] - obs_t[i-1] <= BUSY) begin
                errors++;
                $display("FAIL burst_gap%0d: got %0d need > %0d",
                         i, obs_t[i] - obs_t[i-1], BUSY);
            end
        end
        wait_idle(100);
    endtask

    task automatic test_random();
        int acc = 0;
        int k = 0;
        mode = 2;
        obs.delete();
        obs_t.delete();
        exp_q.delete();
        while (acc < 20 && k < 2000) begin
            if (acc - obs.size() <= 2 && $urandom_range(0, 3) == 0) begin
                logic [7:0] b;
                b = 8'($urandom);
                exp_q.push_back(b);
                push(b);
                acc++;
            end else begin
                tick();
            end
            k++;
        end
        wait_obs(20, 400);
        wait_idle(100);
        cmp_order("random");
        checks++;
        if (ovf !== 1'b0 || empty !== 1'b1 || level !== 3'd0) begin
            errors++;
            $display("FAIL random_end: ovf=%b empty=%b lvl=%0d need 0 1 0",
                     ovf, empty, level);
        end
    endtask

    task automatic test_overflow();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mode = 0;
        obs.delete();
        obs_t.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (i < DEPTH) exp_q.push_back(b);
            push(b);
        end
        checks++;
        if (level !== 3'd4 || full !== 1'b1 || ovf !== 1'b1 ||
            empty !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full: lvl=%0d full=%b ovf=%b empty=%b need 4 1 1 0",
                     level, full, ovf, empty);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: ovf=%b need 0", ovf);
        end
        cpu_din = 8'hEE;
        cpu_wr  = 1'b1;
        ovf_clr = 1'b1;
        tick();
        cpu_wr  = 1'b0;
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b1 || level !== 3'd4) begin
            errors++;
            $display("FAIL ovf_clr_drop: ovf=%b lvl=%0d need 1 4",
                     ovf, level);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0 || obs.size() != 0) begin
            errors++;
            $display("FAIL ovf_clr2: ovf=%b strobes=%0d need 0 0",
                     ovf, obs.size());
        end
    endtask

    task automatic test_push_pop();
        logic [7:0] b;
        b = 8'($urandom);
        exp_q.push_back(b);
        mode    = 1;
        cpu_din = b;
        cpu_wr  = 1'b1;
        tick();
        cpu_wr  = 1'b0;
        checks++;
        if (level !== 3'd4 || full !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL push_pop: lvl=%0d full=%b ovf=%b need 4 1 0",
                     level, full, ovf);
        end
    endtask

    task automatic test_timeout();
        wait_obs(5, 200);
        wait_idle(40);
        cmp_order("timeout");
        for (int i = 1; i < obs_t.size(); i++) begin
            checks++;
            if (obs_t[i] - obs_t[i-1] != TOUT + 3) begin
                errors++;
                $display("FAIL tout_gap%0d: got %0d need %0d",
                         i, obs_t[i] - obs_t[i-1], TOUT + 3);
            end
        end
    endtask

    task automatic test_rst_mid();
        mode = 2;
        obs.delete();
        obs_t.delete();
        cpu_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_din = 8'(8'h10 + i);
            tick();
        end
        cpu_wr = 1'b0;
        wait_obs(1, 20);
        tick();
        checks++;
        if (level !== 3'd3 || busy !== 1'b1 || psg_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre: lvl=%0d busy=%b rdy=%b need 3 1 0",
                     level, busy, psg_ready);
        end
        rst = 1'b1;
        tick();
        chk_reset_outs("mid_reset");
        rst  = 1'b0;
        mode = 1;
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (obs.size() != 1 || empty !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: strobes=%0d empty=%b busy=%b need 1 1 0",
                     obs.size(), empty, busy);
        end
    endtask

    initial begin
        rst     = 1'b1;
        cpu_wr  = 1'b0;
        cpu_din = 8'h00;
        ovf_clr = 1'b0;
        test_reset();
        test_latency();
        test_burst();
        test_random();
        test_overflow();
        test_push_pop();
        test_timeout();
        test_rst_mid();
        checks++;
        if (dbl_low != 0) begin
            errors++;
            $display("FAIL strobe_width: %0d wide strobes, need 0", dbl_low);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
